// File: rtl/mem_lane_sequencer.sv
// Serializes the three per-lane accesses of a vector load/store onto a single-port
// synchronous data RAM, stalling the pipeline buffers until the sequence completes.
module mem_lane_sequencer #(
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] addr     [3],
    input  logic [DATA_W-1:0] wdata    [3],
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic [DATA_W-1:0] memRData,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    output logic              memWE,
    output logic [DATA_W-1:0] readData [3],
    output logic              stall,
    output logic              done
);

    localparam int LANES = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L0   = 3'd1,
        L1   = 3'd2,
        L2   = 3'd3,
        CAP  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t     state, state_nxt;
    logic       req;
    logic       cap_en;
    logic [1:0] cap_lane;

    assign req = MemWrite | MemtoReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read data for lane k returns one cycle after its address, so lane k is
    // captured in the state following Lk; MemWrite wins when both flags are set.
    always_comb begin
        state_nxt = state;
        memAddr   = '0;
        memWData  = '0;
        memWE     = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        cap_en    = 1'b0;
        cap_lane  = 2'd0;
        case (state)
            IDLE: begin
                if (req) begin
                    stall     = 1'b1;
                    state_nxt = L0;
                end
            end
            L0: begin
                memAddr   = addr[0];
                memWData  = wdata[0];
                memWE     = MemWrite;
                stall     = 1'b1;
                state_nxt = L1;
            end
            L1: begin
                memAddr   = addr[1];
                memWData  = wdata[1];
                memWE     = MemWrite;
                stall     = 1'b1;
                cap_en    = ~MemWrite;
                cap_lane  = 2'd0;
                state_nxt = L2;
            end
            L2: begin
                memAddr   = addr[2];
                memWData  = wdata[2];
                memWE     = MemWrite;
                stall     = 1'b1;
                cap_en    = ~MemWrite;
                cap_lane  = 2'd1;
                state_nxt = MemWrite ? DONE : CAP;
            end
            CAP: begin
                stall     = 1'b1;
                cap_en    = 1'b1;
                cap_lane  = 2'd2;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Keep the buffers loading while reset holds the FSM, even if req is high.
        if (reset) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                readData[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (cap_en && cap_lane == 2'(i)) begin
                    readData[i] <= memRData;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_lane_sequencer.sv
// Directed bench for mem_lane_sequencer with a synchronous RAM model behind it.
module tb_mem_lane_sequencer;

    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] addr     [3];
    logic [DW-1:0] wdata    [3];
    logic          MemWrite;
    logic          MemtoReg;
    logic [DW-1:0] memRData;
    logic [DW-1:0] memAddr;
    logic [DW-1:0] memWData;
    logic          memWE;
    logic [DW-1:0] readData [3];
    logic          stall;
    logic          done;

    logic [DW-1:0] ram [256];
    logic          pre_we;
    logic [7:0]    pre_addr;
    logic [DW-1:0] pre_data;

    logic [DW-1:0] wl_addr [16];
    logic [DW-1:0] wl_data [16];
    int            wl_n;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] st_a, dn_a, we_a, st_b, dn_b, we_b;

    mem_lane_sequencer #(.DATA_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .MemWrite (MemWrite),
        .MemtoReg (MemtoReg),
        .memRData (memRData),
        .memAddr  (memAddr),
        .memWData (memWData),
        .memWE    (memWE),
        .readData (readData),
        .stall    (stall),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (memWE) begin
            ram[memAddr[7:0]] <= memWData;
        end
        memRData <= ram[memAddr[7:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic set_instr(input logic we, input logic ld,
                             input logic [DW-1:0] a0, input logic [DW-1:0] a1, input logic [DW-1:0] a2,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        MemWrite = we;
        MemtoReg = ld;
        addr[0] = a0; addr[1] = a1; addr[2] = a2;
        wdata[0] = d0; wdata[1] = d1; wdata[2] = d2;
    endtask

    // Samples ncyc cycles at the falling edge, starting in the current cycle.
    task automatic observe(input int ncyc, output logic [31:0] st, output logic [31:0] dn,
                           output logic [31:0] we);
        st = '0; dn = '0; we = '0;
        wl_n = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            st[c] = stall;
            dn[c] = done;
            we[c] = memWE;
            if (memWE && wl_n < 16) begin
                wl_addr[wl_n] = memAddr;
                wl_data[wl_n] = memWData;
                wl_n++;
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        reset = 1'b1;
        set_instr(1'b0, 1'b1, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0);
        repeat (3) @(posedge clk);
        #1;
        // Reset state, with a load request pending at the inputs
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_we", {31'd0, memWE}, 32'd0);
        check_eq("rst_addr", 32'(memAddr), 32'd0);
        check_eq("rst_wdata", 32'(memWData), 32'd0);
        check_eq("rst_rd0", 32'(readData[0]), 32'd0);
        check_eq("rst_rd2", 32'(readData[2]), 32'd0);
        MemtoReg = 1'b0;
        reset = 1'b0;

        preload(8'd10, 18'h000AA);
        preload(8'd11, 18'h000BB);
        preload(8'd12, 18'h000CC);
        preload(8'd20, 18'd7);
        preload(8'd21, 18'd8);
        preload(8'd22, 18'd9);
        preload(8'd40, 18'h00A1);
        preload(8'd41, 18'h00A2);
        preload(8'd42, 18'h00A3);
        preload(8'd60, 18'd0);
        preload(8'd61, 18'd0);
        preload(8'd62, 18'd0);
        preload(8'd70, 18'h3FFFF);
        preload(8'd71, 18'h20000);
        preload(8'd72, 18'h00001);
        next_cycle();

        // Load
        set_instr(1'b0, 1'b1, 18'd10, 18'd11, 18'd12, 18'd0, 18'd0, 18'd0);
        observe(6, st_a, dn_a, we_a);
        check_eq("ld_stall", st_a, 32'b011111);
        check_eq("ld_done", dn_a, 32'b100000);
        check_eq("ld_we", we_a, 32'd0);
        check_eq("ld_rd0", 32'(readData[0]), 32'hAA);
        check_eq("ld_rd1", 32'(readData[1]), 32'hBB);
        check_eq("ld_rd2", 32'(readData[2]), 32'hCC);
        next_cycle();
        MemtoReg = 1'b0;
        next_cycle();

        // Store
        set_instr(1'b1, 1'b0, 18'd4, 18'd5, 18'd6, 18'd1, 18'd2, 18'd3);
        observe(5, st_a, dn_a, we_a);
        check_eq("st_stall", st_a, 32'b01111);
        check_eq("st_done", dn_a, 32'b10000);
        check_eq("st_we", we_a, 32'b01110);
        check_eq("st_nwr", 32'(wl_n), 32'd3);
        check_eq("st_w0", {wl_addr[0][15:0], wl_data[0][15:0]}, {16'd4, 16'd1});
        check_eq("st_w1", {wl_addr[1][15:0], wl_data[1][15:0]}, {16'd5, 16'd2});
        check_eq("st_w2", {wl_addr[2][15:0], wl_data[2][15:0]}, {16'd6, 16'd3});
        check_eq("st_rd_keep", 32'(readData[1]), 32'hBB);
        next_cycle();
        MemWrite = 1'b0;
        next_cycle();
        check_eq("st_ram4", 32'(ram[4]), 32'd1);
        check_eq("st_ram6", 32'(ram[6]), 32'd3);

        // Load {7,8,9}, then both flags set behaves as a store
        set_instr(1'b0, 1'b1, 18'd20, 18'd21, 18'd22, 18'd0, 18'd0, 18'd0);
        observe(6, st_a, dn_a, we_a);
        next_cycle();
        MemtoReg = 1'b0;
        next_cycle();
        set_instr(1'b1, 1'b1, 18'd30, 18'd31, 18'd32, 18'h11, 18'h12, 18'h13);
        observe(5, st_a, dn_a, we_a);
        check_eq("both_stall", st_a, 32'b01111);
        check_eq("both_we", we_a, 32'b01110);
        next_cycle();
        set_instr(1'b0, 1'b0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0);
        next_cycle();
        check_eq("both_rd0", 32'(readData[0]), 32'd7);
        check_eq("both_rd1", 32'(readData[1]), 32'd8);
        check_eq("both_rd2", 32'(readData[2]), 32'd9);
        check_eq("both_ram31", 32'(ram[31]), 32'h12);

        // Load immediately followed by a store
        set_instr(1'b0, 1'b1, 18'd40, 18'd41, 18'd42, 18'd0, 18'd0, 18'd0);
        observe(6, st_a, dn_a, we_a);
        next_cycle();
        set_instr(1'b1, 1'b0, 18'd50, 18'd51, 18'd52, 18'h21, 18'h22, 18'h23);
        observe(5, st_b, dn_b, we_b);
        check_eq("b2b_stall", {st_b[4:0], st_a[5:0]} , 32'b01111_011111);
        check_eq("b2b_done", {dn_b[4:0], dn_a[5:0]}, 32'b10000_100000);
        check_eq("b2b_we", {we_b[4:0], we_a[5:0]}, 32'b01110_000000);
        next_cycle();
        MemWrite = 1'b0;
        next_cycle();
        check_eq("b2b_rd1", 32'(readData[1]), 32'hA2);
        check_eq("b2b_ram52", 32'(ram[52]), 32'h23);

        // Reset during L1 of a store
        set_instr(1'b1, 1'b0, 18'd60, 18'd61, 18'd62, 18'd5, 18'd6, 18'd7);
        next_cycle();
        next_cycle();
        check_eq("rl1_pre_addr", 32'(memAddr), 32'd61);
        check_eq("rl1_pre_we", {31'd0, memWE}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rl1_we", {31'd0, memWE}, 32'd0);
        check_eq("rl1_addr", 32'(memAddr), 32'd0);
        check_eq("rl1_wdata", 32'(memWData), 32'd0);
        check_eq("rl1_stall", {31'd0, stall}, 32'd0);
        check_eq("rl1_done", {31'd0, done}, 32'd0);
        check_eq("rl1_rd", {readData[0][9:0], readData[1][9:0], readData[2][9:0]}, 32'd0);
        MemWrite = 1'b0;
        next_cycle();
        reset = 1'b0;
        observe(4, st_a, dn_a, we_a);
        check_eq("rl1_post", {st_a[3:0], dn_a[3:0], we_a[3:0]}, 32'd0);
        check_eq("rl1_ram60", 32'(ram[60]), 32'd5);
        check_eq("rl1_ram61", 32'(ram[61]), 32'd0);
        check_eq("rl1_ram62", 32'(ram[62]), 32'd0);

        // Full-range load data, then 20 idle cycles
        next_cycle();
        set_instr(1'b0, 1'b1, 18'd70, 18'd71, 18'd72, 18'd0, 18'd0, 18'd0);
        observe(6, st_a, dn_a, we_a);
        next_cycle();
        MemtoReg = 1'b0;
        observe(20, st_a, dn_a, we_a);
        check_eq("idle_stall", st_a, 32'd0);
        check_eq("idle_done", dn_a, 32'd0);
        check_eq("idle_we", we_a, 32'd0);
        check_eq("idle_rd0", 32'(readData[0]), 32'h3FFFF);
        check_eq("idle_rd1", 32'(readData[1]), 32'h20000);
        check_eq("idle_rd2", 32'(readData[2]), 32'h00001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
